// File: rtl/mem_access_unit.sv
// Load/store initiator: turns one RV32I B/H/W access at a time into word-wide memory
// transactions, using read-modify-write for sub-word stores. Optional MAU_BOUNDS_CHECK_EN adds a range check.
module mem_access_unit #(
  parameter int MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ren,
  output logic [15:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_wen,
  output logic [15:0] mem_waddr,
  output logic [31:0] mem_wdata
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic        err_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [15:0] waddr_q;
  logic [31:0] merged_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        acc_err;

  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [31:0] a);
    logic e;
    case (f3)
      F3_B:         e = 1'b0;
      F3_H:         e = a[0];
      F3_W:         e = |a[1:0];
      F3_BU:        e = we;
      F3_HU:        e = we | a[0];
      default:      e = 1'b1;
    endcase
`ifdef MAU_BOUNDS_CHECK_EN
    if ({2'b00, a[31:2]} >= 32'(MEM_DEPTH)) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] w, input logic [1:0] lane,
                                               input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'd0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] lane, input logic [2:0] f3);
    logic [31:0] r;
    r = w;
    case (f3)
      F3_B: begin
        case (lane)
          2'd0:    r[7:0]   = d[7:0];
          2'd1:    r[15:8]  = d[7:0];
          2'd2:    r[23:16] = d[7:0];
          default: r[31:24] = d[7:0];
        endcase
      end
      F3_H: begin
        if (lane[1]) r[31:16] = d[15:0];
        else         r[15:0]  = d[15:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  assign accept  = (state_q == IDLE) && req_valid;
  assign acc_err = req_error(req_we, req_funct3, req_addr);

  // Control state: the only registers that see reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) err_q <= acc_err;
    end
  end

  // Request capture, then load extraction or store merge in READ
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= req_we;
      f3_q     <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      waddr_q  <= req_addr[17:2];
      merged_q <= req_wdata;
      rdata_q  <= 32'd0;
    end else if (state_q == READ) begin
      if (we_q) merged_q <= merge_store(mem_rdata, wdata_q, addr_q[1:0], f3_q);
      else      rdata_q  <= extract_load(mem_rdata, addr_q[1:0], f3_q);
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    mem_ren    = 1'b0;
    mem_raddr  = 16'd0;
    mem_wen    = 1'b0;
    mem_waddr  = 16'd0;
    mem_wdata  = 32'd0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (acc_err)                                  state_d = RESP;
          else if (req_we && (req_funct3 == F3_W))      state_d = WRITE;
          else                                          state_d = READ;
        end
      end
      READ: begin
        mem_ren   = 1'b1;
        mem_raddr = waddr_q;
        state_d   = we_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_wen   = 1'b1;
        mem_waddr = waddr_q;
        mem_wdata = merged_q;
        state_d   = RESP;
      end
      default: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        state_d    = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected responses,
// a negedge monitor pops and compares them against the DUT and a small memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ren;
  logic [15:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_wen;
  logic [15:0] mem_waddr;
  logic [31:0] mem_wdata;

  mem_access_unit #(.MEM_DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, registered write
  logic [31:0] mem [0:255];
  logic        preload = 1'b0;
  assign mem_rdata = mem[mem_raddr[7:0]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[255] <= 32'hCAFEF00D;
    end else if (mem_wen) begin
      mem[mem_waddr[7:0]] <= mem_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          ren;
    int          wen;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   nfail = 0;
  int   ren_cnt = 0;
  int   wen_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      ren_cnt = 0;
      wen_cnt = 0;
    end else begin
      if (mem_ren) begin
        ren_cnt++;
        if (q.size() > 0) chk("mem_raddr", 64'(mem_raddr), 64'(q[0].addr));
      end else begin
        chk("raddr_idle", 64'(mem_raddr), 64'd0);
      end
      if (mem_wen) begin
        wen_cnt++;
        if (q.size() == 0) chk("wen_unexpected", 64'(mem_wen), 64'd0);
        else begin
          chk("mem_waddr", 64'(mem_waddr), 64'(q[0].addr));
          chk("mem_wdata", 64'(mem_wdata), 64'(q[0].wdata));
        end
      end else begin
        chk("write_idle", {16'd0, mem_waddr, mem_wdata}, 64'd0);
      end
      if (resp_valid) begin
        if (q.size() == 0) chk("resp_unexpected", 64'(resp_valid), 64'd0);
        else begin
          e = q.pop_front();
          chk("resp_err", 64'(resp_err), 64'(e.err));
          chk("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
          chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
          chk("ren_count", 64'(ren_cnt), 64'(e.ren));
          chk("wen_count", 64'(wen_cnt), 64'(e.wen));
          ren_cnt = 0;
          wen_cnt = 0;
        end
      end else begin
        chk("resp_idle", {31'd0, resp_err, resp_rdata}, 64'd0);
      end
    end
  end

  task automatic drive_accept(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, input logic err, input logic [31:0] rd,
                              input int lat, input int ren, input int wen, input logic [31:0] wd);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before_issue", 64'(req_ready), 64'd1);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    e.err = err; e.rdata = rd; e.lat = lat; e.ren = ren; e.wen = wen;
    e.addr = a[17:2]; e.wdata = wd; e.acc = cyc;
    q.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic err, input logic [31:0] rd,
                       input int lat, input int ren, input int wen, input logic [31:0] wd);
    bit done;
    drive_accept(we, f3, a, d, err, rd, lat, ren, wen, wd);
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      nchk++;
      nfail++;
      $display("FAIL response_timeout: got no response, expected one for addr 0x%0h", a);
      q.delete();
    end
  endtask

  initial begin
    // Reset state
    preload = 1'b1;
    repeat (2) @(negedge clk);
    preload = 1'b0;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_outputs", {resp_valid, resp_err, mem_ren, mem_wen, 28'd0, resp_rdata}, 64'd0);
    chk("reset_addrs", {mem_raddr, mem_waddr, mem_wdata}, 64'd0);
    rst_n = 1'b1;

    // SW, then SB read-modify-write
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, 0, 1, 32'hDEADBEEF);
    issue(1'b1, 3'b000, 32'h11, 32'h123456AA, 1'b0, 32'h0, 3, 1, 1, 32'hDEADAAEF);

    // Loads on 0xDEADAAEF
    issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFFFFDE, 2, 1, 0, 32'h0);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h000000DE, 2, 1, 0, 32'h0);
    issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFFDEAD, 2, 1, 0, 32'h0);
    issue(1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h0000AAEF, 2, 1, 0, 32'h0);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADAAEF, 2, 1, 0, 32'h0);
    issue(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'hFFFFFFEF, 2, 1, 0, 32'h0);
    issue(1'b0, 3'b100, 32'h11, 32'h0, 1'b0, 32'h000000AA, 2, 1, 0, 32'h0);

    // Errors: misaligned and illegal funct3
    issue(1'b0, 3'b010, 32'h02, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0);
    issue(1'b1, 3'b001, 32'h01, 32'h5555, 1'b1, 32'h0, 1, 0, 0, 32'h0);
    issue(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0);
    issue(1'b1, 3'b100, 32'h10, 32'h77, 1'b1, 32'h0, 1, 0, 0, 32'h0);
    issue(1'b0, 3'b101, 32'h11, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0);

    // SH upper half, then read back
    issue(1'b1, 3'b001, 32'h12, 32'h0000BEEF, 1'b0, 32'h0, 3, 1, 1, 32'hBEEFAAEF);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hBEEFAAEF, 2, 1, 0, 32'h0);

    // Reset during the READ cycle of SH 0x10
    drive_accept(1'b1, 3'b001, 32'h10, 32'h00001111, 1'b0, 32'h0, 3, 1, 1, 32'hBEEF1111);
    @(negedge clk);
    #1;
    chk("in_read_before_reset", 64'(mem_ren), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_req_ready", 64'(req_ready), 64'd1);
    chk("reset_mid_outputs", {60'd0, mem_ren, mem_wen, resp_valid, resp_err}, 64'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("reset_no_resp", 64'(resp_valid), 64'd0);
    chk("reset_word_kept", 64'(mem[4]), 64'hBEEFAAEF);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hBEEFAAEF, 2, 1, 0, 32'h0);

    // Top of memory and out-of-range
    issue(1'b0, 3'b010, 32'h3FC, 32'h0, 1'b0, 32'hCAFEF00D, 2, 1, 0, 32'h0);
`ifdef MAU_BOUNDS_CHECK_EN
    issue(1'b0, 3'b010, 32'h400, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0);
    issue(1'b1, 3'b000, 32'h400, 32'h11, 1'b1, 32'h0, 1, 0, 0, 32'h0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that drives the combined instruction/data memory's port on behalf of the core. It accepts one RV32I load or store request at a time and converts byte/halfword/word accesses into word-wide memory transactions. Sub-word stores use read-modify-write, because the memory has no byte enables. It returns one response pulse per request, with the extended load data or an error flag.

## Interface
Parameters:
- MEM_DEPTH, 256: number of 32-bit words in the memory; used by the bounds check.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request; high iff state IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request rejected; valid with resp_valid
- mem_ren  out  1  memory read enable
- mem_raddr  out  16  memory word address for reads
- mem_rdata  in  32  memory read data (combinational from mem_raddr)
- mem_wen  out  1  memory write enable
- mem_waddr  out  16  memory word address for writes
- mem_wdata  out  32  memory write data

## Operation
- **States:** IDLE, READ, WRITE, RESP.
- **Accept:** a request is accepted when req_valid && req_ready at a clock edge. The unit registers we, funct3, addr, wdata and word address addr[17:2].
- **Error check (at accept):**
  - Error conditions: invalid funct3 (011, 110, 111; also 100/101 with we=1); H misaligned (addr[0]=1); W misaligned (addr[1:0]≠0).
  - On error, go to RESP with err=1 and issue no memory access.
- **State transitions:**
  - Load: IDLE→READ→RESP.
  - SW: IDLE→WRITE→RESP.
  - SB/SH: IDLE→READ→WRITE→RESP.
- **READ:**
  - mem_ren=1 and mem_raddr=word address.
  - For a load, the extracted data is captured into resp_rdata at the edge. Byte lane is addr[1:0]; halfword lane is addr[1]. B/H sign-extend; BU/HU zero-extend.
  - For a sub-word store, the merged word is captured at the edge. The merge replaces the addressed byte or halfword of mem_rdata with req_wdata[7:0] or req_wdata[15:0].
- **WRITE:** mem_wen=1, mem_waddr=word address, mem_wdata=merged word (SW: req_wdata).
- **RESP:** resp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- **Idle memory outputs:** when mem_ren/mem_wen are low, the corresponding address and data outputs are 0.
- **Outside RESP:** resp_rdata and resp_err are held at 0.
- **Request inputs:** ignored while req_ready=0.

## Timing
- Latency from accept edge to resp_valid high:
  - Error: 1 cycle.
  - Load or SW: 2 cycles.
  - SB/SH: 3 cycles.
- Throughput: a new request can be accepted in the cycle after RESP (req_ready rises as RESP exits).
- Reset values: state IDLE; req_ready=1; resp_valid, resp_rdata, resp_err, mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata all 0.
- **Reset mid-operation:** all outputs go to reset values immediately (asynchronously).
  - A store whose WRITE state has not reached its clock edge is abandoned; memory is unchanged.
  - No response is issued for the abandoned request.
- **Back-to-back RMW:** the read of store N+1 always observes the write of store N, because WRITE completes before RESP.

## Configuration
- MAU_BOUNDS_CHECK_EN defined:
  - A request with addr[31:2] ≥ MEM_DEPTH is an error: RESP with err=1 and no memory access.
- Undefined:
  - No range check; mem addresses are addr[17:2], and upper bits are ignored.
  - Accesses beyond MEM_DEPTH are the system's responsibility.

## Test plan
- **SW** addr 0x10, data 0xDEADBEEF → one cycle with mem_wen=1, mem_waddr=4, mem_wdata=0xDEADBEEF. resp_valid 2 cycles after accept, err=0, rdata=0.
- **SB** addr 0x11, data 0x123456AA on word 0xDEADBEEF → mem_ren cycle, then mem_wen with wdata=0xDEADAAEF. resp_valid 3 cycles after accept.
- **Loads** on word 0xDEADAAEF at 0x10:
  - LB 0x13 → 0xFFFFFFDE
  - LBU 0x13 → 0x000000DE
  - LH 0x12 → 0xFFFFDEAD
  - LHU 0x10 → 0x0000AAEF
  - LW 0x10 → 0xDEADAAEF
- **Misaligned** LW addr 0x02 and SH addr 0x01 → resp_err=1 and resp_rdata=0, 1 cycle after accept. No mem_ren or mem_wen observed.
- **Reset** rst_n low during the READ cycle of SH addr 0x10 → mem_wen never asserts, word unchanged, resp_valid stays 0. req_ready=1 while rst_n is low.
- **Bounds**, MAU_BOUNDS_CHECK_EN defined, MEM_DEPTH=256: LW addr 0x400 → err=1, no mem_ren; LW addr 0x3FC → normal access to word 255.
